// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding, applies decode redirects.
// Optional FETCH_BUBBLE_COUNT_EN adds a free-running count of bubbles delivered to IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] pc_branch_D,
  input  logic        JumpD,
  input  logic [31:0] pc_jump_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_F,
  output logic [31:0] pc_plus_four_F,
  output logic        fetch_bubble_F
`ifdef FETCH_BUBBLE_COUNT_EN
  ,output logic [31:0] fetch_bubble_count
`endif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_next;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic         kill;
  logic         buf_valid;
  fetch_entry_t buf_entry;

  logic         redirect;
  logic [31:0]  target;
  logic         resp;
  logic         resp_live;
  logic         slot_free;
  logic         grant;

  assign redirect  = (PCSrcD | JumpD) & ~StallF;
  assign target    = (PCSrcD ? pc_branch_D : pc_jump_D) & ~32'h3;
  assign resp      = imem_rvalid & inflight;
  // A response racing a redirect is already wrong-path, same as a killed one.
  assign resp_live = resp & ~kill & ~redirect;
  assign slot_free = ~inflight | resp;
  assign imem_req  = slot_free & ~StallF & reset_n;
  assign imem_addr = redirect ? target : pc_next;
  assign grant     = imem_req & imem_gnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_next     <= RESET_PC & ~32'h3;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      kill        <= 1'b0;
    end else begin
      if (grant) begin
        inflight    <= 1'b1;
        inflight_pc <= imem_addr;
        pc_next     <= imem_addr + 32'd4;
      end else begin
        if (resp)     inflight <= 1'b0;
        if (redirect) pc_next  <= target;
      end
      if (resp)
        kill <= 1'b0;
      else if (redirect & inflight)
        kill <= 1'b1;
    end
  end

  // Hold entry: catches a good response that lands while IF/ID is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_entry <= '0;
    end else begin
      if (redirect & inflight & ~resp) begin
        buf_valid <= 1'b0;
      end else if (resp_live & StallF) begin
        buf_valid       <= 1'b1;
        buf_entry.instr <= imem_rdata;
        buf_entry.pc    <= inflight_pc;
      end else if (buf_valid & ~StallF) begin
        buf_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    instruction_F  = 32'h0;
    pc_plus_four_F = 32'h0;
    fetch_bubble_F = 1'b1;
    if (buf_valid) begin
      instruction_F  = buf_entry.instr;
      pc_plus_four_F = buf_entry.pc + 32'd4;
      fetch_bubble_F = 1'b0;
    end else if (resp_live) begin
      instruction_F  = imem_rdata;
      pc_plus_four_F = inflight_pc + 32'd4;
      fetch_bubble_F = 1'b0;
    end
  end

`ifdef FETCH_BUBBLE_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      fetch_bubble_count <= 32'h0;
    else if (~StallF & fetch_bubble_F)
      fetch_bubble_count <= fetch_bubble_count + 32'd1;
  end
`else
  // Bubble counter not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed checks of fetch timing plus a random run against an architectural PC-stream model.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        StallF = 1'b0, PCSrcD = 1'b0, JumpD = 1'b0;
  logic [31:0] pc_branch_D = 32'h0, pc_jump_D = 32'h0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] instruction_F, pc_plus_four_F;
  logic        fetch_bubble_F;
`ifdef FETCH_BUBBLE_COUNT_EN
  logic [31:0] fetch_bubble_count;
  logic [31:0] cnt_mark;
`endif

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset_n(reset_n), .StallF(StallF),
    .PCSrcD(PCSrcD), .pc_branch_D(pc_branch_D), .JumpD(JumpD), .pc_jump_D(pc_jump_D),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_F(instruction_F), .pc_plus_four_F(pc_plus_four_F),
    .fetch_bubble_F(fetch_bubble_F)
`ifdef FETCH_BUBBLE_COUNT_EN
    , .fetch_bubble_count(fetch_bubble_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, lat = 1;
  logic mem_resp;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge: apply inputs, present the memory's response, settle.
  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic g, input logic spur);
    StallF = st; PCSrcD = br; pc_branch_D = bt; JumpD = jp; pc_jump_D = jt; imem_gnt = g;
    mem_resp = (pend.size() > 0) && (pend[0].due <= cyc);
    if (mem_resp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memw(pend[0].addr);
    end else begin
      imem_rvalid = spur && (pend.size() == 0);
      imem_rdata  = $urandom;
    end
    #1;
  endtask

  task automatic advance();
    if (mem_resp) void'(pend.pop_front());
    if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic nop_step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    advance();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    mem_resp = 1'b0;
    #1;
    chk("rst_instr", instruction_F, 32'h0);
    chk("rst_pp4", pc_plus_four_F, 32'h0);
    chk("rst_bubble", 32'(fetch_bubble_F), 32'h1);
    chk("rst_req", 32'(imem_req), 32'h0);
`ifdef FETCH_BUBBLE_COUNT_EN
    chk("rst_count", fetch_bubble_count, 32'h0);
`endif
    pend.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  logic [31:0] exp_pc;
  int ndeliv, nbub;
  logic st, br, jp, g, spur;
  logic [31:0] bt, jt;

  initial begin
    @(negedge clock);
    // Straight-line fetch, 1-cycle memory
    lat = 1;
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_c0_req", 32'(imem_req), 32'h1);
    chk("t1_c0_addr", imem_addr, RESET_PC);
    chk("t1_c0_bubble", 32'(fetch_bubble_F), 32'h1);
    advance();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("t1_pp4", pc_plus_four_F, 32'(4 * i));
      chk("t1_instr", instruction_F, memw(32'(4 * (i - 1))));
      chk("t1_bubble", 32'(fetch_bubble_F), 32'h0);
      chk("t1_addr", imem_addr, 32'(4 * i));
      advance();
    end

    // Branch in the cycle the response for 0x8 arrives
    do_reset();
    repeat (3) nop_step();
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_bubble", 32'(fetch_bubble_F), 32'h1);
    chk("t2_addr", imem_addr, 32'h40);
    chk("t2_req", 32'(imem_req), 32'h1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_pp4", pc_plus_four_F, 32'h44);
    chk("t2_instr", instruction_F, memw(32'h40));
    advance();

    // Jump while a 3-cycle request is in flight; target low bits must be dropped
    lat = 3;
    do_reset();
    nop_step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1, 1'b0);
    chk("t3_c1_req", 32'(imem_req), 32'h0);
    chk("t3_c1_bubble", 32'(fetch_bubble_F), 32'h1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_c2_bubble", 32'(fetch_bubble_F), 32'h1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_c3_bubble", 32'(fetch_bubble_F), 32'h1);
    chk("t3_c3_req", 32'(imem_req), 32'h1);
    chk("t3_c3_addr", imem_addr, 32'h100);
    advance();
    repeat (2) nop_step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_pp4", pc_plus_four_F, 32'h104);
    chk("t3_instr", instruction_F, memw(32'h100));
    advance();

    // Stall on the 0x10 response, then grant starvation, then reset mid-flight
    lat = 1;
    do_reset();
    repeat (5) nop_step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("t4_stall_req", 32'(imem_req), 32'h0);
      advance();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_pp4", pc_plus_four_F, 32'h14);
    chk("t4_instr", instruction_F, memw(32'h10));
    chk("t4_req", 32'(imem_req), 32'h1);
    chk("t4_addr", imem_addr, 32'h14);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_c8_pp4", pc_plus_four_F, 32'h18);
    chk("t5_c8_addr", imem_addr, 32'h18);
    advance();
`ifdef FETCH_BUBBLE_COUNT_EN
    cnt_mark = fetch_bubble_count;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, (i == 2), 1'b0);
      chk("t5_bubble", 32'(fetch_bubble_F), 32'h1);
      chk("t5_req", 32'(imem_req), 32'h1);
      chk("t5_addr", imem_addr, 32'h18);
      advance();
    end
    lat = 3;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_pp4", pc_plus_four_F, 32'h1C);
`ifdef FETCH_BUBBLE_COUNT_EN
    chk("t5_count_delta", fetch_bubble_count - cnt_mark, 32'd3);
    chk("t5_count", fetch_bubble_count, 32'd4);
`endif
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_inflight_req", 32'(imem_req), 32'h0);
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_restart_req", 32'(imem_req), 32'h1);
    chk("t6_restart_addr", imem_addr, RESET_PC);

    // Random run: delivered stream must follow the architectural PC sequence
    exp_pc = RESET_PC; ndeliv = 0; nbub = 0;
    for (int n = 0; n < 800; n++) begin
      st   = ($urandom_range(0, 4) == 0);
      br   = ($urandom_range(0, 15) == 0);
      jp   = ($urandom_range(0, 15) == 0);
      bt   = $urandom & 32'h0000_FFFF;
      jt   = $urandom & 32'h000F_FFFF;
      g    = ($urandom_range(0, 3) != 0);
      spur = ($urandom_range(0, 3) == 0);
      lat  = $urandom_range(1, 3);
      drive(st, br, bt, jp, jt, g, spur);
      chk("rnd_align", 32'(imem_addr[1:0]), 32'h0);
      if (st) chk("rnd_stall_req", 32'(imem_req), 32'h0);
      if (!st) begin
        if (!fetch_bubble_F) begin
          chk("rnd_pp4", pc_plus_four_F, exp_pc + 32'd4);
          chk("rnd_instr", instruction_F, memw(exp_pc));
          exp_pc = exp_pc + 32'd4;
          ndeliv++;
        end else begin
          chk("rnd_bubble_zero", instruction_F | pc_plus_four_F, 32'h0);
          nbub++;
        end
        if (br || jp) exp_pc = (br ? bt : jt) & ~32'h3;
      end
      advance();
    end
    chk("rnd_progress", 32'(ndeliv >= 60), 32'h1);
`ifdef FETCH_BUBBLE_COUNT_EN
    chk("rnd_count", fetch_bubble_count, 32'(nbub));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the IF/ID pipeline register. It owns the PC register and issues word fetches to instruction memory through a request/grant/response handshake, with at most one request outstanding. It applies decode-stage redirects (taken branch, jump) and discards wrong-path responses. It presents `instruction_F` and `pc_plus_four_F` to the IF/ID register, or a NOP bubble (0x00000000) when no instruction is ready.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; word-aligned.

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `StallF`  in  1  hazard-unit stall; holds the fetch stage and the IF/ID register
- `PCSrcD`  in  1  taken branch in decode
- `pc_branch_D`  in  32  branch target
- `JumpD`  in  1  jump in decode
- `pc_jump_D`  in  32  jump target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; bits [1:0] always 0
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid
- `imem_rdata`  in  32  response instruction word
- `instruction_F`  out  32  instruction to IF/ID
- `pc_plus_four_F`  out  32  address of `instruction_F` plus 4
- `fetch_bubble_F`  out  1  current output is a bubble

## Operation
- State registers:
  - `pc_next`: next fetch address
  - `inflight`, `inflight_pc`
  - `kill`: the in-flight response is wrong-path
  - `buf_valid`, `buf_instr`, `buf_pc`: single hold entry
- Redirect condition: `(PCSrcD | JumpD) & !StallF`.
  - `PCSrcD` has priority over `JumpD`.
  - Target bits [1:0] are forced to 0.
  - A redirect is ignored while `StallF=1`.
- `slot_free = !inflight | (imem_rvalid & inflight)`.
- `imem_req = slot_free & !StallF`.
- `imem_addr` = redirect target during a redirect, otherwise `pc_next`.
- Request is granted when `imem_req & imem_gnt`:
  - `inflight` <= 1
  - `inflight_pc` <= `imem_addr`
  - `pc_next` <= `imem_addr + 4`, wrapping mod 2^32
- Request not granted: the request persists. Its address may change when a redirect arrives.
- Redirect with no grant: `pc_next` <= target.
- Response handling, when `imem_rvalid & inflight`:
  - The response retires: `inflight` <= 0 unless re-granted in the same cycle.
  - If `kill=1`, or a redirect occurs in the same cycle, the response is discarded and `kill` <= 0.
  - Otherwise, if `StallF=1`: `buf` <= {`imem_rdata`, `inflight_pc`}.
  - Otherwise the response is presented directly at the output.
- Redirect while `inflight & !imem_rvalid`: `kill` <= 1 and `buf_valid` <= 0.
- Output mux, in priority order:
  1. `buf_valid`: output the buffer. It is consumed when `StallF=0`, then `buf_valid` <= 0.
  2. A live response: output `imem_rdata`.
  3. Otherwise a bubble: `instruction_F=0`, `pc_plus_four_F=0`, `fetch_bubble_F=1`.
- `imem_rvalid` with `inflight=0` is ignored.

## Timing
- Reset (async assert) clears all state:
  - `pc_next`=`RESET_PC`; `inflight`, `kill`, `buf_valid` = 0
  - `instruction_F`=0, `pc_plus_four_F`=0, `fetch_bubble_F`=1
  - `imem_req`=0 while `reset_n`=0
- In the first cycle after reset deassertion, `imem_req`=1 with `imem_addr`=`RESET_PC` (provided `StallF=0`).
- Memory responds at least 1 cycle after grant, in order, exactly one response per grant.
- With a 1-cycle memory and `imem_gnt`=1 constantly, throughput is 1 instruction per cycle. The first instruction is at the output in cycle 1 after reset release.
- Redirect penalty:
  - Response arriving in the redirect cycle: 1 bubble. The target request issues in the redirect cycle.
  - Otherwise: 1 bubble plus the remaining latency of the stale request.
- Outputs are combinational from registered state and `imem_rdata`. The IF/ID register captures them at the edge.
- Reset mid-operation drops any outstanding request. Instruction memory is reset on the same `reset_n`.

## Configuration
- `FETCH_BUBBLE_COUNT_EN` defined: adds output `fetch_bubble_count` (out, 32). It resets to 0 and increments (wrapping) on every edge where `!StallF & fetch_bubble_F`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, memory with 1-cycle latency and `gnt`=1 -> requests at addresses 0, 4, 8; `instruction_F` shows each word with `pc_plus_four_F` = 4, 8, 12; no bubbles after the first cycle.
- `PCSrcD`=1 with `pc_branch_D`=0x40 in the same cycle the response for 0x8 arrives -> that response is discarded, `imem_addr`=0x40 in the same cycle, one bubble, then `pc_plus_four_F`=0x44.
- 3-cycle memory, `JumpD`=1 to 0x100 while a request is in flight -> stale response discarded (NOP output), request to 0x100 issues in the cycle the stale response arrives, then `pc_plus_four_F`=0x104.
- `StallF`=1 in the cycle the response for 0x10 arrives -> `imem_req`=0; word held. After 2 stall cycles with `StallF`=0, the held word is output with `pc_plus_four_F`=0x14, and the next request is 0x14.
- `imem_gnt`=0 for 3 cycles -> `imem_req` stays high with stable `imem_addr`, bubbles are output, and `fetch_bubble_count`=3 with the macro defined.
- `reset_n` pulsed low while a request is in flight -> outputs return to reset values immediately; fetch restarts at `RESET_PC`.
